timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel down-counting timer bank, the next generation of the single-channel timer. It provides NUM_CH independent WIDTH-bit channels with per-channel one-shot or periodic (auto-reload) mode, sticky interrupt-pending flags with clear, and a shared programmable prescaler. It sits between the register/control logic and the interrupt aggregation logic, which consumes `io_irq`.

## Interface
- NUM_CH, 4, number of independent timer channels (1..16)
- WIDTH, 32, counter and load-value width in bits
- PRESC_W, 8, prescaler divide-value width in bits
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- io_prescale  in  PRESC_W  tick divider: one count tick every io_prescale+1 cycles
- io_enable  in  NUM_CH  per-channel count enable
- io_periodic  in  NUM_CH  per-channel mode: 1 = auto-reload, 0 = one-shot
- io_load_valid  in  NUM_CH  per-channel load strobe, one cycle
- io_load_value  in  NUM_CH*WIDTH  load values, channel i at bits [i*WIDTH +: WIDTH]
- io_irq_en  in  NUM_CH  per-channel interrupt enable
- io_irq_clr  in  NUM_CH  per-channel pending-flag clear strobe
- io_timerValue  out  NUM_CH*WIDTH  current counts, same packing as io_load_value
- io_timeout  out  NUM_CH  registered one-cycle expiry pulse per channel
- io_irq_pending  out  NUM_CH  sticky pending flags
- io_irq  out  1  OR over channels of (io_irq_pending & io_irq_en)

## Operation
- Per-channel state: count[WIDTH], reload[WIDTH], armed (1 bit), pending (1 bit), timeout register.
- Shared tick: prescaler counter pc counts 0..io_prescale. `tick` = (pc == io_prescale), and pc returns to 0 on tick. With io_prescale = 0, tick is high every cycle. The prescaler runs whenever out of reset, independent of channel enables. If io_prescale is changed below the current pc, pc wraps through its maximum value; this behaviour is legal.
- Channel events are evaluated each cycle in priority order:
  - Load (io_load_valid[i]): count <= reload <= value; armed <= 1; no expiry this cycle. The load ignores tick and enable.
  - Decrement (tick & enable & armed & count != 0): count <= count - 1.
  - Expiry (tick & enable & armed & count == 0): timeout pulse.
    - Periodic mode: count <= reload.
    - One-shot mode: armed <= 0, and count holds at 0 until the next load.
  - Otherwise count holds. io_enable low freezes the count.
- Period in periodic mode = reload + 1 ticks. Reload = 0 expires on every tick.
- A disarmed channel with count 0 never produces a timeout. After reset, every channel is disarmed until it is loaded.
- Pending flag:
  - Set on expiry when io_irq_en[i] = 1.
  - Cleared by io_irq_clr[i]. When set and clear occur in the same cycle, set wins.
  - Deasserting io_irq_en masks io_irq but keeps the flag.
- Arithmetic is unsigned, modulo 2^WIDTH. No underflow is possible because decrement requires count != 0.

## Timing
- Reset (reset_n = 0 at an edge): all count, reload, pc = 0; armed = 0; io_timeout = 0; io_irq_pending = 0; io_irq = 0.
  - Reset applied mid-count aborts all channels immediately.
- A load at edge k makes io_timerValue show the value from k+1.
- Decrement is visible one cycle after the tick cycle.
- io_timeout[i] is high for exactly the one cycle following the expiry cycle. In periodic mode the reloaded count is visible in that same cycle.
- io_irq_pending rises in the same cycle as io_timeout.
- io_irq is combinational from registered pending and io_irq_en.

## Configuration
- TIMER_BANK_PRESCALER_EN
  - Defined: the shared prescaler is present as described above.
  - Undefined: the prescaler is not instantiated, tick = 1 every cycle, and io_prescale is ignored. This is cycle-identical to the defined case with io_prescale = 0.

## Test plan
- Periodic, prescale 0: load 3 on ch0 with enable=1, periodic=1.
  - Required: timerValue 3,2,1,0,3,2,...
  - Required: io_timeout[0] pulses every 4 cycles, each pulse coinciding with the value 3.
- One-shot: load 2 on ch1, periodic=0.
  - Required: a single timeout pulse, after which the count stays at 0 with no further pulses.
  - Reload to 5: the channel runs again.
- Prescaler: io_prescale=2, load 1, periodic.
  - Required: the count changes only every 3rd cycle.
  - Required: timeout every 6 cycles.
- Interrupts: irq_en[2]=1, expiry sets pending, io_irq=1.
  - irq_clr on the same cycle as a subsequent expiry: pending stays 1.
  - Clear alone: pending goes to 0.
  - irq_en=0 with pending=1: io_irq=0.
- Collisions: load on the same cycle as an expiry gives no timeout and takes the new value.
  - Channels 0..3 loaded with 0,1,2,3 simultaneously: pulse periods are 1,2,3,4 cycles, independent of each other.
- Reset: assert reset_n=0 mid-count on all channels.
  - Required: all outputs 0 the next cycle.
  - Required: no timeouts until the channels are reloaded.

Source files
------------

// File: rtl/timer_bank_if.sv
// Control/status bundle for timer_bank: load, mode and interrupt controls in,
// per-channel counts, expiry pulses and interrupt status out.
interface timer_bank_if #(
   parameter int NUM_CH  = 4,
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
);
   logic [PRESC_W-1:0]      io_prescale;
   logic [NUM_CH-1:0]       io_enable;
   logic [NUM_CH-1:0]       io_periodic;
   logic [NUM_CH-1:0]       io_load_valid;
   logic [NUM_CH*WIDTH-1:0] io_load_value;
   logic [NUM_CH-1:0]       io_irq_en;
   logic [NUM_CH-1:0]       io_irq_clr;
   logic [NUM_CH*WIDTH-1:0] io_timerValue;
   logic [NUM_CH-1:0]       io_timeout;
   logic [NUM_CH-1:0]       io_irq_pending;
   logic                    io_irq;

   modport master (
      output io_prescale, io_enable, io_periodic, io_load_valid, io_load_value,
             io_irq_en, io_irq_clr,
      input  io_timerValue, io_timeout, io_irq_pending, io_irq
   );

   modport slave (
      input  io_prescale, io_enable, io_periodic, io_load_valid, io_load_value,
             io_irq_en, io_irq_clr,
      output io_timerValue, io_timeout, io_irq_pending, io_irq
   );
endinterface

// File: rtl/timer_bank.sv
// NUM_CH down-counting timers sharing one tick; one-shot or auto-reload per channel.
// Define TIMER_BANK_PRESCALER_EN to build the shared prescaler; otherwise tick every cycle.
module timer_bank #(
   parameter int NUM_CH  = 4,
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input logic          clk,
   input logic          reset_n,
   timer_bank_if.slave  bus
);
   logic                tick;
   logic [WIDTH-1:0]    count_q  [NUM_CH];
   logic [WIDTH-1:0]    count_d  [NUM_CH];
   logic [WIDTH-1:0]    reload_q [NUM_CH];
   logic [WIDTH-1:0]    reload_d [NUM_CH];
   logic [NUM_CH-1:0]   armed_q, armed_d;
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [NUM_CH-1:0]   timeout_q, timeout_d;

`ifdef TIMER_BANK_PRESCALER_EN
   logic [PRESC_W-1:0]  pc_q, pc_d;

   // Lowering io_prescale below pc_q lets pc wrap through its maximum first.
   always_comb begin
      tick = (pc_q == bus.io_prescale);
      pc_d = tick ? '0 : pc_q + PRESC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) pc_q <= '0;
      else          pc_q <= pc_d;
   end
`else
   logic unused_prescale;
   assign unused_prescale = ^bus.io_prescale;
   assign tick = 1'b1;
`endif

   // Priority per channel: load, then decrement, then terminal-count expiry.
   always_comb begin
      count_d   = count_q;
      reload_d  = reload_q;
      armed_d   = armed_q;
      timeout_d = '0;
      pending_d = pending_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.io_load_valid[i]) begin
            count_d[i]  = bus.io_load_value[i*WIDTH +: WIDTH];
            reload_d[i] = bus.io_load_value[i*WIDTH +: WIDTH];
            armed_d[i]  = 1'b1;
         end else if (tick && bus.io_enable[i] && armed_q[i]) begin
            if (count_q[i] != '0) begin
               count_d[i] = count_q[i] - WIDTH'(1);
            end else begin
               timeout_d[i] = 1'b1;
               if (bus.io_periodic[i]) count_d[i] = reload_q[i];
               else                    armed_d[i] = 1'b0;
            end
         end
         if (timeout_d[i] && bus.io_irq_en[i]) pending_d[i] = 1'b1;
         else if (bus.io_irq_clr[i])           pending_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i]  <= '0;
            reload_q[i] <= '0;
         end
         armed_q   <= '0;
         pending_q <= '0;
         timeout_q <= '0;
      end else begin
         count_q   <= count_d;
         reload_q  <= reload_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         timeout_q <= timeout_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_value
      assign bus.io_timerValue[g*WIDTH +: WIDTH] = count_q[g];
   end

   assign bus.io_timeout     = timeout_q;
   assign bus.io_irq_pending = pending_q;
   assign bus.io_irq         = |(pending_q & bus.io_irq_en);
endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: hand-derived vector table on channel 0,
// then directed multi-channel sequences and random traffic against a reference model.
module tb_timer_bank;
   localparam int NCH = 4;
   localparam int W   = 32;
   localparam int PW  = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   timer_bank_if #(.NUM_CH(NCH), .WIDTH(W), .PRESC_W(PW)) bus ();
   timer_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESC_W(PW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [NCH*W-1:0] tv;
      logic [NCH-1:0]   to;
      logic [NCH-1:0]   pend;
      logic             irq;
   } exp_t;

   typedef struct {
      logic        lv;
      logic [W-1:0] val;
      logic        en, per, ien, clr;
      logic [W-1:0] tv0;
      logic        to, pend, irq;
   } vec_t;

   exp_t  sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   string phase   = "reset";

   logic [W-1:0]   m_count  [NCH];
   logic [W-1:0]   m_reload [NCH];
   logic [NCH-1:0] m_armed, m_pend, m_to;
   logic [PW-1:0]  m_pc;

   int last_to [NCH];
   int gap     [NCH];
   int npulse  [NCH];

   function automatic vec_t v(logic lv, int val, logic en, logic per, logic ien, logic clr,
                              int tv0, logic to, logic pend, logic irq);
      vec_t r;
      r.lv = lv; r.val = W'(val); r.en = en; r.per = per; r.ien = ien; r.clr = clr;
      r.tv0 = W'(tv0); r.to = to; r.pend = pend; r.irq = irq;
      return r;
   endfunction

   task automatic check(input string nm, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s@%0d: got %0h expected %0h", phase, nm, cyc, act, exp);
      end
   endtask

   // Reference model: next-cycle outputs from the inputs currently driven.
   task automatic model_step(output exp_t e);
      logic          tk;
      logic [PW-1:0] pe;
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_count[c] = '0;
            m_reload[c] = '0;
         end
         m_armed = '0; m_pend = '0; m_to = '0; m_pc = '0;
      end else begin
`ifdef TIMER_BANK_PRESCALER_EN
         pe = bus.io_prescale;
`else
         pe = '0;
`endif
         tk   = (m_pc == pe);
         m_pc = tk ? '0 : m_pc + 8'd1;
         for (int c = 0; c < NCH; c++) begin
            m_to[c] = 1'b0;
            if (bus.io_load_valid[c]) begin
               m_count[c]  = bus.io_load_value[c*W +: W];
               m_reload[c] = bus.io_load_value[c*W +: W];
               m_armed[c]  = 1'b1;
            end else if (tk && bus.io_enable[c] && m_armed[c]) begin
               if (m_count[c] == 0) begin
                  m_to[c] = 1'b1;
                  if (bus.io_periodic[c]) m_count[c] = m_reload[c];
                  else                    m_armed[c] = 1'b0;
               end else begin
                  m_count[c] = m_count[c] - 1;
               end
            end
            if (m_to[c] && bus.io_irq_en[c]) m_pend[c] = 1'b1;
            else if (bus.io_irq_clr[c])      m_pend[c] = 1'b0;
         end
      end
      for (int c = 0; c < NCH; c++) e.tv[c*W +: W] = m_count[c];
      e.to   = m_to;
      e.pend = m_pend;
      e.irq  = |(m_pend & bus.io_irq_en);
   endtask

   task automatic clear_track();
      for (int c = 0; c < NCH; c++) begin
         last_to[c] = -1; gap[c] = -1; npulse[c] = 0;
      end
   endtask

   task automatic step(input bit use_tab, input exp_t e_tab);
      exp_t e, got;
      model_step(e);
      sb_q.push_back(use_tab ? e_tab : e);
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         got = sb_q.pop_front();
         check("timerValue", bus.io_timerValue, got.tv);
         check("timeout", NCH*W'(bus.io_timeout), NCH*W'(got.to));
         check("pending", NCH*W'(bus.io_irq_pending), NCH*W'(got.pend));
         check("irq", NCH*W'(bus.io_irq), NCH*W'(got.irq));
      end
      for (int c = 0; c < NCH; c++) begin
         if (bus.io_timeout[c]) begin
            if (last_to[c] >= 0) gap[c] = cyc - last_to[c];
            last_to[c] = cyc;
            npulse[c]++;
         end
      end
   endtask

   task automatic run(input int n);
      exp_t dummy;
      dummy = '{default: '0};
      for (int k = 0; k < n; k++) begin
         step(1'b0, dummy);
         bus.io_load_valid = '0;
         bus.io_irq_clr    = '0;
      end
   endtask

   task automatic idle_inputs();
      bus.io_prescale   = '0;
      bus.io_enable     = '0;
      bus.io_periodic   = '0;
      bus.io_load_valid = '0;
      bus.io_load_value = '0;
      bus.io_irq_en     = '0;
      bus.io_irq_clr    = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab [21];
      exp_t et;
      int   tot;

      tab[0]  = v(1, 3, 1, 1, 1, 0,  3, 0, 0, 0);
      tab[1]  = v(0, 0, 1, 1, 1, 0,  2, 0, 0, 0);
      tab[2]  = v(0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      tab[3]  = v(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      tab[4]  = v(0, 0, 1, 1, 1, 0,  3, 1, 1, 1);
      tab[5]  = v(0, 0, 1, 1, 1, 1,  2, 0, 0, 0);
      tab[6]  = v(0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      tab[7]  = v(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      tab[8]  = v(0, 0, 1, 1, 1, 1,  3, 1, 1, 1);
      tab[9]  = v(0, 0, 1, 1, 0, 0,  2, 0, 1, 0);
      tab[10] = v(0, 0, 0, 1, 0, 0,  2, 0, 1, 0);
      tab[11] = v(0, 0, 1, 0, 1, 0,  1, 0, 1, 1);
      tab[12] = v(0, 0, 1, 0, 1, 0,  0, 0, 1, 1);
      tab[13] = v(0, 0, 1, 0, 1, 0,  0, 1, 1, 1);
      tab[14] = v(0, 0, 1, 0, 1, 0,  0, 0, 1, 1);
      tab[15] = v(0, 0, 1, 0, 1, 0,  0, 0, 1, 1);
      tab[16] = v(1, 5, 1, 0, 1, 0,  5, 0, 1, 1);
      tab[17] = v(0, 0, 1, 0, 1, 0,  4, 0, 1, 1);
      tab[18] = v(1, 0, 1, 1, 1, 0,  0, 0, 1, 1);
      tab[19] = v(0, 0, 1, 1, 1, 0,  0, 1, 1, 1);
      tab[20] = v(1, 7, 1, 1, 1, 0,  7, 0, 1, 1);

      idle_inputs();
      clear_track();
      reset_n = 1'b0;
      run(2);
      reset_n = 1'b1;

      phase = "table";
      for (int r = 0; r < 21; r++) begin
         bus.io_load_valid = {3'b0, tab[r].lv};
         bus.io_load_value = '0;
         bus.io_load_value[W-1:0] = tab[r].val;
         bus.io_enable   = {3'b0, tab[r].en};
         bus.io_periodic = {3'b0, tab[r].per};
         bus.io_irq_en   = {3'b0, tab[r].ien};
         bus.io_irq_clr  = {3'b0, tab[r].clr};
         et.tv   = '0;
         et.tv[W-1:0] = tab[r].tv0;
         et.to   = {3'b0, tab[r].to};
         et.pend = {3'b0, tab[r].pend};
         et.irq  = tab[r].irq;
         step(1'b1, et);
      end

      phase = "oneshot";
      idle_inputs();
      run(1);
      clear_track();
      bus.io_enable = 4'b0010;
      bus.io_load_valid = 4'b0010;
      bus.io_load_value[W +: W] = 2;
      run(10);
      check("oneshot_pulses", NCH*W'(npulse[1]), NCH*W'(1));
      clear_track();
      bus.io_load_valid = 4'b0010;
      bus.io_load_value[W +: W] = 5;
      run(12);
      check("reload_pulses", NCH*W'(npulse[1]), NCH*W'(1));

      phase = "prescale";
      idle_inputs();
      clear_track();
      bus.io_prescale   = 8'd2;
      bus.io_enable     = 4'b0100;
      bus.io_periodic   = 4'b0100;
      bus.io_irq_en     = 4'b0100;
      bus.io_load_valid = 4'b0100;
      bus.io_load_value[2*W +: W] = 1;
      run(20);
`ifdef TIMER_BANK_PRESCALER_EN
      check("presc_period", NCH*W'(gap[2]), NCH*W'(6));
`else
      check("presc_period", NCH*W'(gap[2]), NCH*W'(2));
`endif
      bus.io_irq_clr = 4'b0100;
      run(1);
      bus.io_irq_en = 4'b0000;
      run(8);

      phase = "multi";
      idle_inputs();
      run(1);
      clear_track();
      bus.io_enable     = 4'b1111;
      bus.io_periodic   = 4'b1111;
      bus.io_irq_en     = 4'b1111;
      bus.io_load_valid = 4'b1111;
      for (int c = 0; c < NCH; c++) bus.io_load_value[c*W +: W] = W'(c);
      run(12);
      for (int c = 0; c < NCH; c++)
         check($sformatf("period_ch%0d", c), NCH*W'(gap[c]), NCH*W'(c + 1));

      phase = "midreset";
      bus.io_load_valid = 4'b1111;
      for (int c = 0; c < NCH; c++) bus.io_load_value[c*W +: W] = W'(10 + c);
      run(3);
      reset_n = 1'b0;
      run(1);
      reset_n = 1'b1;
      clear_track();
      run(8);
      tot = npulse[0] + npulse[1] + npulse[2] + npulse[3];
      check("post_reset_pulses", NCH*W'(tot), '0);

      phase = "random";
      idle_inputs();
      for (int k = 0; k < 300; k++) begin
         if (k % 40 == 0) bus.io_prescale = PW'($urandom_range(0, 3));
         for (int c = 0; c < NCH; c++) begin
            bus.io_load_valid[c] = ($urandom_range(0, 7) == 0);
            bus.io_load_value[c*W +: W] = W'($urandom_range(0, 6));
            bus.io_irq_clr[c] = ($urandom_range(0, 5) == 0);
         end
         if (k % 10 == 0) begin
            bus.io_enable   = NCH'($urandom_range(0, 15) | 3);
            bus.io_periodic = NCH'($urandom_range(0, 15));
            bus.io_irq_en   = NCH'($urandom_range(0, 15));
         end
         run(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
